// File: rtl/img_pkg.sv
// Shared video definitions for the pre-filter and the downstream processing stage.
package img_pkg;

   localparam int PIX_W = 8;
   localparam int DEF_IMAGE_W = 640;
   localparam int DEF_IMAGE_H = 480;

   // Low nibble of a descriptor beat that marks a video packet.
   localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

   typedef struct packed {
      logic [PIX_W-1:0] r;
      logic [PIX_W-1:0] g;
      logic [PIX_W-1:0] b;
   } rgb_t;

endpackage

// File: rtl/hsmooth_tap3.sv
// Single-channel [1 2 1]/4 kernel, optionally rounded; purely combinational.
module hsmooth_tap3
   import img_pkg::*;
#(
   parameter int ROUND_EN = 1
) (
   input  logic [PIX_W-1:0] a,
   input  logic [PIX_W-1:0] b,
   input  logic [PIX_W-1:0] c,
   output logic [PIX_W-1:0] y
);

   localparam logic [PIX_W+1:0] BIAS = (ROUND_EN != 0) ? (PIX_W+2)'(2) : '0;

   logic [PIX_W+1:0] sum;

   // Max is 4*255+2 = 1022, so the shifted result always fits in PIX_W bits.
   always_comb begin
      sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + BIAS;
      y   = sum[PIX_W+1:2];
   end

endmodule

// File: rtl/rgb_hsmooth_filter.sv
// Avalon-ST RGB pre-filter: causal 3-tap horizontal smoothing on video packets,
// with a one-deep registered output stage; other packets pass through untouched.
module rgb_hsmooth_filter
   import img_pkg::*;
#(
   parameter int IMAGE_W  = DEF_IMAGE_W,
   parameter int ROUND_EN = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [3*PIX_W-1:0]   sink_data,
   input  logic                 sink_valid,
   output logic                 sink_ready,
   input  logic                 sink_sop,
   input  logic                 sink_eop,
   output logic [3*PIX_W-1:0]   source_data,
   output logic                 source_valid,
   input  logic                 source_ready,
   output logic                 source_sop,
   output logic                 source_eop
);

   localparam int XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);

   logic [XW-1:0]        x_q, x_d;
   logic                 packet_video_q, packet_video_d;
   rgb_t                 p1_q, p1_d, p2_q, p2_d;
   logic [3*PIX_W-1:0]   data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 sop_q, sop_d;
   logic                 eop_q, eop_d;

   rgb_t                 cur;
   rgb_t                 tap_a;
   rgb_t                 filt;
   logic                 accept;
   logic                 filter_on;

   assign sink_ready   = ~valid_q | source_ready;
   assign accept       = sink_valid & sink_ready;
   assign cur          = rgb_t'(sink_data);
   // Column 1 has only one real predecessor, so it is mirrored into the outer tap.
   assign tap_a        = (x_q == XW'(1)) ? p1_q : p2_q;
   assign filter_on    = packet_video_q & enable & (x_q != '0);

   assign source_data  = data_q;
   assign source_valid = valid_q;
   assign source_sop   = sop_q;
   assign source_eop   = eop_q;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         hsmooth_tap3 #(
            .ROUND_EN (ROUND_EN)
         ) u_tap (
            .a (tap_a[gi*PIX_W +: PIX_W]),
            .b (p1_q[gi*PIX_W +: PIX_W]),
            .c (cur[gi*PIX_W +: PIX_W]),
            .y (filt[gi*PIX_W +: PIX_W])
         );
      end
   endgenerate

   always_comb begin
      x_d            = x_q;
      packet_video_d = packet_video_q;
      p1_d           = p1_q;
      p2_d           = p2_q;
      data_d         = data_q;
      sop_d          = sop_q;
      eop_d          = eop_q;
      valid_d        = valid_q;

      if (accept) begin
         valid_d = 1'b1;
         sop_d   = sink_sop;
         eop_d   = sink_eop;
         if (sink_sop) begin
            data_d         = sink_data;
            packet_video_d = (sink_data[3:0] == PKT_TYPE_VIDEO);
            x_d            = '0;
         end else begin
            data_d = filter_on ? filt : sink_data;
            // History shifts even when bypassing so an enable change mid-row is clean.
            if (x_q == '0) begin
               p1_d = cur;
               p2_d = cur;
            end else begin
               p1_d = cur;
               p2_d = p1_q;
            end
            x_d = (x_q == X_LAST) ? '0 : x_q + XW'(1);
         end
      end else if (source_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_q            <= '0;
         packet_video_q <= 1'b0;
         p1_q           <= '0;
         p2_q           <= '0;
         data_q         <= '0;
         valid_q        <= 1'b0;
         sop_q          <= 1'b0;
         eop_q          <= 1'b0;
      end else begin
         x_q            <= x_d;
         packet_video_q <= packet_video_d;
         p1_q           <= p1_d;
         p2_q           <= p2_d;
         data_q         <= data_d;
         valid_q        <= valid_d;
         sop_q          <= sop_d;
         eop_q          <= eop_d;
      end
   end

endmodule

// File: tb/tb_rgb_hsmooth_filter.sv
// Directed scoreboard bench for rgb_hsmooth_filter (IMAGE_W=640, ROUND_EN=1).
module tb_rgb_hsmooth_filter;

   localparam int W = 640;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [23:0] sink_data;
   logic        sink_valid;
   logic        sink_ready;
   logic        sink_sop;
   logic        sink_eop;
   logic [23:0] source_data;
   logic        source_valid;
   logic        source_ready;
   logic        source_sop;
   logic        source_eop;

   int errors = 0;
   int checks = 0;
   int beat_no = 0;

   logic [25:0] sbq[$];
   logic [23:0] exp_const[$];

   // reference model state
   logic        m_video;
   int          m_x;
   logic [23:0] m_p1, m_p2;

   always #5 clk = ~clk;

   rgb_hsmooth_filter #(
      .IMAGE_W  (W),
      .ROUND_EN (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .sink_data    (sink_data),
      .sink_valid   (sink_valid),
      .sink_ready   (sink_ready),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .source_data  (source_data),
      .source_valid (source_valid),
      .source_ready (source_ready),
      .source_sop   (source_sop),
      .source_eop   (source_eop)
   );

   function automatic logic [7:0] f3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      int s;
      s = int'(a) + 2 * int'(b) + int'(c) + 2;
      return 8'(s / 4);
   endfunction

   function automatic logic [23:0] fpix(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
      return {f3(a[23:16], b[23:16], c[23:16]), f3(a[15:8], b[15:8], c[15:8]), f3(a[7:0], b[7:0], c[7:0])};
   endfunction

   function automatic void model_reset();
      m_video = 1'b0;
      m_x     = 0;
      m_p1    = '0;
      m_p2    = '0;
   endfunction

   function automatic logic [23:0] model_step(input logic [23:0] d, input logic s);
      logic [23:0] o;
      if (s) begin
         o       = d;
         m_video = (d[3:0] == 4'h0);
         m_x     = 0;
      end else begin
         if (m_video && enable && m_x == 1)      o = fpix(m_p1, m_p1, d);
         else if (m_video && enable && m_x >= 2) o = fpix(m_p2, m_p1, d);
         else                                    o = d;
         if (m_x == 0) begin
            m_p1 = d;
            m_p2 = d;
         end else begin
            m_p2 = m_p1;
            m_p1 = d;
         end
         m_x = (m_x == W - 1) ? 0 : m_x + 1;
      end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one beat, wait (bounded) for acceptance, push its expectation.
   task automatic send(input logic [23:0] d, input logic s, input logic e);
      int n;
      logic [23:0] o;
      n = 0;
      sink_data  = d;
      sink_sop   = s;
      sink_eop   = e;
      sink_valid = 1'b1;
      @(negedge clk);
      while (!sink_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk("accept_timeout", 32'(n), 32'd0);
      end else begin
         o = model_step(d, s);
         if (exp_const.size() != 0) o = exp_const.pop_front();
         sbq.push_back({o, s, e});
      end
      @(posedge clk);
      #1;
      sink_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while ((sbq.size() != 0 || source_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", 32'(sbq.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      logic [25:0] e;
      if (reset_n && source_valid && source_ready) begin
         checks++;
         assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL extra_beat observed=%h expected=none", source_data);
         end
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            $display("beat %0d data=%h sop=%0b eop=%0b", beat_no, source_data, source_sop, source_eop);
            assert ({source_data, source_sop, source_eop} === e) else begin
               errors++;
               $error("FAIL beat%0d observed=%h/%0b%0b expected=%h/%0b%0b", beat_no,
                      source_data, source_sop, source_eop, e[25:2], e[1], e[0]);
            end
            beat_no++;
         end
      end
   end

   initial begin
      int step_in[6]  = '{0, 0, 0, 255, 255, 255};
      int step_out[6] = '{0, 0, 0, 64, 191, 255};
      logic [23:0] px;

      reset_n = 1'b0; enable = 1'b1; source_ready = 1'b1;
      sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {5'd0, source_valid, source_sop, source_eop, source_data},
          {5'd0, 3'b000, 24'h0});
      chk("reset_sink_ready", 32'(sink_ready), 32'd1);
      reset_n = 1'b1;

      // Flat row: every pixel and the descriptor come out unchanged.
      exp_const.push_back(24'h000000);
      send(24'h000000, 1'b1, 1'b0);
      for (int i = 0; i < W; i++) begin
         exp_const.push_back(24'h808080);
         send(24'h808080, 1'b0, i == W - 1);
      end
      wait_empty();

      // Step edge on red.
      exp_const.push_back(24'h000000);
      send(24'h000000, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         exp_const.push_back({8'(step_out[i]), 16'h0});
         send({8'(step_in[i]), 16'h0}, 1'b0, i == 5);
      end
      wait_empty();

      // Row wrap: row0 of 100s, row1 starts 0,200 without blending row0.
      send(24'h000000, 1'b1, 1'b0);
      for (int i = 0; i < W; i++) begin
         exp_const.push_back(24'h646464);
         send(24'h646464, 1'b0, 1'b0);
      end
      exp_const.push_back(24'h000000);
      send(24'h000000, 1'b0, 1'b0);
      exp_const.push_back(24'h323232);
      send(24'hC8C8C8, 1'b0, 1'b1);
      wait_empty();

      // Non-video packet, with enable on and off.
      for (int k = 0; k < 2; k++) begin
         enable = (k == 0);
         exp_const.push_back(24'h00000F);
         send(24'h00000F, 1'b1, 1'b0);
         exp_const.push_back(24'h123456);
         send(24'h123456, 1'b0, 1'b0);
         exp_const.push_back(24'h000000);
         send(24'h000000, 1'b0, 1'b1);
      end
      enable = 1'b1;
      // sop+eop on one beat acts as a descriptor.
      send(24'h0000A0, 1'b1, 1'b1);
      wait_empty();

      // Varied video row with an enable toggle in the middle.
      send(24'h000010, 1'b1, 1'b0);
      for (int i = 0; i < 24; i++) begin
         if (i == 8)  enable = 1'b0;
         if (i == 14) enable = 1'b1;
         px = {8'(i * 37), 8'(255 - i * 11), 8'(i * i)};
         send(px, 1'b0, i == 23);
      end
      wait_empty();

      // Backpressure mid-row.
      send(24'h000000, 1'b1, 1'b0);
      send(24'h102030, 1'b0, 1'b0);
      send(24'h405060, 1'b0, 1'b0);
      wait_empty();
      source_ready = 1'b0;
      send(24'hF0E0D0, 1'b0, 1'b0);
      sink_data = 24'h0A0B0C; sink_sop = 1'b0; sink_eop = 1'b0; sink_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_sink_ready", 32'(sink_ready), 32'd0);
         chk("bp_hold", {7'd0, source_valid, source_data}, {7'd0, 1'b1, sbq[0][25:2]});
      end
      @(posedge clk);
      #1;
      source_ready = 1'b1;
      send(24'h0A0B0C, 1'b0, 1'b0);
      send(24'h777777, 1'b0, 1'b1);
      wait_empty();

      // Mid-packet reset at pixel 300.
      send(24'h000000, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         send({8'(i), ~8'(i), 8'(i) ^ 8'h5A}, 1'b0, 1'b0);
      end
      reset_n = 1'b0;
      chk("inflight_beats", 32'(sbq.size()), 32'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      sbq.delete();
      model_reset();
      chk("post_reset_valid", 32'(source_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         px = {8'(i * 50), 8'(200 - i * 30), 8'(i * 9)};
         exp_const.push_back(px);
         send(px, 1'b0, 1'b0);
      end
      send(24'h000000, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send({8'(i * 60), 8'(i * 13), 8'(255 - i * 25)}, 1'b0, i == 7);
      end
      wait_empty();
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
